// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: two producer FIFOs (ALU path A, load path M) drained one write per cycle.
// Optional macro WB_RR_EN selects round-robin arbitration; default build gives M fixed priority over A.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RSTa,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          m_valid,
    input  logic [AW-1:0] m_reg,
    input  logic [DW-1:0] m_data,
    output logic          m_ready,
    output logic          RegWrite,
    output logic [AW-1:0] writeReg,
    output logic [DW-1:0] writeData,
    input  logic [AW-1:0] query_reg1,
    input  logic [AW-1:0] query_reg2,
    output logic          pending1,
    output logic          pending2,
    output logic          idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_C = (PW + 1)'(DEPTH);

    // Source index 0 is the ALU path, index 1 is the load path.
    logic [AW-1:0]    mem_reg_r  [2][DEPTH];
    logic [DW-1:0]    mem_data_r [2][DEPTH];
    logic [DEPTH-1:0] mem_vld_r  [2];
    logic [PW-1:0]    rd_ptr_r   [2];
    logic [PW-1:0]    wr_ptr_r   [2];
    logic [PW:0]      count_r    [2];

    logic [AW-1:0]    req_reg_s  [2];
    logic [DW-1:0]    req_data_s [2];
    logic [AW-1:0]    head_reg_s [2];
    logic [DW-1:0]    head_data_s[2];
    logic [1:0]       req_valid_s;
    logic [1:0]       ready_s;
    logic [1:0]       push_s;
    logic [1:0]       nonempty_s;
    logic [1:0]       pop_s;

    logic             reg_write_r;
    logic [AW-1:0]    write_reg_r;
    logic [DW-1:0]    write_data_r;
    logic             hit1_s;
    logic             hit2_s;

    assign req_valid_s   = {m_valid, a_valid};
    assign req_reg_s[0]  = a_reg;
    assign req_reg_s[1]  = m_reg;
    assign req_data_s[0] = a_data;
    assign req_data_s[1] = m_data;

    // Per-source handshake, x0 filtering and head-of-queue views.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ready_s[s]     = (count_r[s] != FULL_C);
            nonempty_s[s]  = (count_r[s] != '0);
            push_s[s]      = req_valid_s[s] && ready_s[s] && (req_reg_s[s] != '0);
            head_reg_s[s]  = mem_reg_r[s][rd_ptr_r[s]];
            head_data_s[s] = mem_data_r[s][rd_ptr_r[s]];
        end
    end

`ifdef WB_RR_EN
    logic last_grant_m_r;

    // Grant selection: alternate between sources whenever both have work.
    always_comb begin
        pop_s = 2'b00;
        if (nonempty_s == 2'b11) begin
            if (last_grant_m_r) begin
                pop_s = 2'b01;
            end else begin
                pop_s = 2'b10;
            end
        end else begin
            pop_s = nonempty_s;
        end
    end

    // Remember which source won the most recent grant.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            last_grant_m_r <= 1'b0;
        end else if (pop_s != 2'b00) begin
            last_grant_m_r <= pop_s[1];
        end
    end
`else
    // Grant selection: the load path always wins when both have work.
    always_comb begin
        pop_s = 2'b00;
        if (nonempty_s == 2'b11) begin
            pop_s = 2'b10;
        end else begin
            pop_s = nonempty_s;
        end
    end
`endif

    // FIFO storage, pointers and occupancy for both sources.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_r[s]  <= '0;
                wr_ptr_r[s]  <= '0;
                count_r[s]   <= '0;
                mem_vld_r[s] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_reg_r[s][i]  <= '0;
                    mem_data_r[s][i] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push_s[s]) begin
                    mem_reg_r[s][wr_ptr_r[s]]  <= req_reg_s[s];
                    mem_data_r[s][wr_ptr_r[s]] <= req_data_s[s];
                    mem_vld_r[s][wr_ptr_r[s]]  <= 1'b1;
                    wr_ptr_r[s]                <= wr_ptr_r[s] + 1'b1;
                end
                if (pop_s[s]) begin
                    mem_vld_r[s][rd_ptr_r[s]] <= 1'b0;
                    rd_ptr_r[s]               <= rd_ptr_r[s] + 1'b1;
                end
                case ({push_s[s], pop_s[s]})
                    2'b10:   count_r[s] <= count_r[s] + 1'b1;
                    2'b01:   count_r[s] <= count_r[s] - 1'b1;
                    default: count_r[s] <= count_r[s];
                endcase
            end
        end
    end

    // Write-port register: address and data hold when nothing is granted.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= '0;
            write_data_r <= '0;
        end else if (pop_s[1]) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= head_reg_s[1];
            write_data_r <= head_data_s[1];
        end else if (pop_s[0]) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= head_reg_s[0];
            write_data_r <= head_data_s[0];
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    // Hazard lookup across every live FIFO slot of both sources.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit1_s = hit1_s | (mem_vld_r[s][i] && (mem_reg_r[s][i] == query_reg1));
                hit2_s = hit2_s | (mem_vld_r[s][i] && (mem_reg_r[s][i] == query_reg2));
            end
        end
    end

    assign pending1  = (query_reg1 != '0) && (hit1_s || (reg_write_r && (write_reg_r == query_reg1)));
    assign pending2  = (query_reg2 != '0) && (hit2_s || (reg_write_r && (write_reg_r == query_reg2)));
    assign a_ready   = ready_s[0];
    assign m_ready   = ready_s[1];
    assign RegWrite  = reg_write_r;
    assign writeReg  = write_reg_r;
    assign writeData = write_data_r;
    assign idle      = (count_r[0] == '0) && (count_r[1] == '0) && !reg_write_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised scoreboard bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RSTa = 1'b0;
    logic          a_valid = 1'b0, m_valid = 1'b0;
    logic [AW-1:0] a_reg = '0, m_reg = '0, query_reg1 = '0, query_reg2 = '0;
    logic [DW-1:0] a_data = '0, m_data = '0;
    logic          a_ready, m_ready, RegWrite, pending1, pending2, idle;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .query_reg1(query_reg1), .query_reg2(query_reg2),
        .pending1(pending1), .pending2(pending2), .idle(idle)
    );

    // Reference state: FIFO contents as queues, producer backlogs, expected writes.
    wr_t qa[$], qm[$], expq[$], reqA[$], reqM[$];
    int  wlog[$];
    bit            mrw = 1'b0;
    logic [AW-1:0] mreg = '0;
    bit            last_a = 1'b1;
    bit            rand_q = 1'b0, gaps = 1'b0;
    logic [AW-1:0] q1_fix = '0, q2_fix = '0;
    int  n_vec = 0, n_err = 0;
    int  exp_order[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pend_model(input logic [AW-1:0] q);
        if (q == '0) return 1'b0;
        if (mrw && mreg == q) return 1'b1;
        foreach (qa[i]) if (qa[i].r == q) return 1'b1;
        foreach (qm[i]) if (qm[i].r == q) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the reference: arbitrate on pre-edge occupancy, pop, then accept.
    task automatic model_edge();
        bit  rdy_a, rdy_m, ga, gm;
        wr_t w;
        rdy_a = (qa.size() != DEPTH);
        rdy_m = (qm.size() != DEPTH);
        if (qa.size() != 0 && qm.size() != 0) begin
`ifdef WB_RR_EN
            gm = last_a;
`else
            gm = 1'b1;
`endif
            ga = !gm;
        end else begin
            gm = (qm.size() != 0);
            ga = (qa.size() != 0);
        end
        if (gm || ga) begin
            w = gm ? qm.pop_front() : qa.pop_front();
            mrw = 1'b1;
            mreg = w.r;
            expq.push_back(w);
            last_a = ga;
        end else begin
            mrw = 1'b0;
        end
        if (a_valid && rdy_a) begin
            if (a_reg != '0) qa.push_back({a_reg, a_data});
            void'(reqA.pop_front());
        end
        if (m_valid && rdy_m) begin
            if (m_reg != '0) qm.push_back({m_reg, m_data});
            void'(reqM.pop_front());
        end
    endtask

    // Drive one cycle of producer/query inputs, then advance the model across the edge.
    task automatic step();
        a_valid = (reqA.size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
        m_valid = (reqM.size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
        if (reqA.size() != 0) begin a_reg = reqA[0].r; a_data = reqA[0].d; end
        if (reqM.size() != 0) begin m_reg = reqM[0].r; m_data = reqM[0].d; end
        if (rand_q) begin
            query_reg1 = AW'($urandom_range(0, 7));
            query_reg2 = AW'($urandom_range(0, 7));
        end else begin
            query_reg1 = q1_fix;
            query_reg2 = q2_fix;
        end
        @(posedge CLK);
        model_edge();
        #2;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((reqA.size() != 0 || reqM.size() != 0 || qa.size() != 0 || qm.size() != 0 || mrw) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles", budget);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    // Monitor: compare every observable output against the model on the falling edge.
    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge CLK);
            check("RegWrite", 32'(RegWrite), 32'(mrw));
            if (RegWrite === 1'b1) begin
                wlog.push_back(int'(writeReg));
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got reg %0d data %0h expected no write", writeReg, writeData);
                end else begin
                    w = expq.pop_front();
                    check("writeReg", 32'(writeReg), 32'(w.r));
                    check("writeData", writeData, w.d);
                end
            end
            check("a_ready", 32'(a_ready), 32'(qa.size() != DEPTH));
            check("m_ready", 32'(m_ready), 32'(qm.size() != DEPTH));
            check("idle", 32'(idle), 32'(qa.size() == 0 && qm.size() == 0 && !mrw));
            check("pending1", 32'(pending1), 32'(pend_model(query_reg1)));
            check("pending2", 32'(pending2), 32'(pend_model(query_reg2)));
        end
    end

    initial begin : stimulus
`ifdef WB_RR_EN
        exp_order = '{3, 1, 4, 2};
`else
        exp_order = '{3, 4, 1, 2};
`endif
        #17 RSTa = 1'b1;

        // Single write with hazard tracking on r5.
        q1_fix = 5'd5;
        reqA.push_back({5'd5, 32'hDEADBEEF});
        drain(50);

        // Load to x0: handshake completes, nothing written or pending.
        q1_fix = 5'd0;
        reqM.push_back({5'd0, 32'h0000_1234});
        drain(50);

        // A backlog of three while M floods the port.
        q1_fix = 5'd1;
        q2_fix = 5'd3;
        for (int i = 0; i < 8; i++) reqM.push_back({AW'(10 + i), $urandom()});
        for (int i = 1; i <= 3; i++) reqA.push_back({AW'(i), $urandom()});
        drain(100);

        // Both FIFOs loaded with two entries on the same edges.
        wlog.delete();
        reqA.push_back({5'd1, 32'hA1});
        reqA.push_back({5'd2, 32'hA2});
        reqM.push_back({5'd3, 32'hB3});
        reqM.push_back({5'd4, 32'hB4});
        drain(50);
        check("arb_count", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4)
            for (int i = 0; i < 4; i++) check("arb_order", 32'(wlog[i]), 32'(exp_order[i]));

        // Randomised traffic with gaps, x0 requests and random queries.
        rand_q = 1'b1;
        gaps = 1'b1;
        for (int i = 0; i < 150; i++) begin
            reqA.push_back({AW'($urandom_range(0, 7)), $urandom()});
            reqM.push_back({AW'($urandom_range(0, 7)), $urandom()});
        end
        drain(3000);
        rand_q = 1'b0;
        gaps = 1'b0;

        // Asynchronous reset with three entries queued and a write in flight.
        q1_fix = 5'd6;
        q2_fix = 5'd7;
        reqA.push_back({5'd6, 32'h66});
        reqA.push_back({5'd7, 32'h77});
        reqA.push_back({5'd8, 32'h88});
        reqM.push_back({5'd9, 32'h99});
        reqM.push_back({5'd11, 32'hBB});
        step();
        step();
        check("pre_reset_queued", 32'(qa.size() + qm.size()), 32'd3);
        check("pre_reset_RegWrite", 32'(RegWrite), 32'd1);
        #1 RSTa = 1'b0;
        #1;
        check("reset_RegWrite", 32'(RegWrite), 32'd0);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_pending1", 32'(pending1), 32'd0);
        check("reset_pending2", 32'(pending2), 32'd0);
        check("reset_a_ready", 32'(a_ready), 32'd1);
        qa.delete(); qm.delete(); expq.delete(); reqA.delete(); reqM.delete();
        mrw = 1'b0;
        last_a = 1'b1;
        a_valid = 1'b0;
        m_valid = 1'b0;
        @(posedge CLK);
        #2 RSTa = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Post-reset traffic still retires normally.
        reqA.push_back({5'd12, 32'hC0FFEE});
        reqM.push_back({5'd13, 32'hBEEF});
        drain(50);

        check("leftover_expected", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file's single write port. Two producers feed it through valid/ready handshakes: the ALU path (A) and the load/memory path (M). Each producer has its own small FIFO. The block drains one queued write per cycle into the register file's RegWrite/writeReg/writeData inputs. It also reports per-register pending status to the decode stage for hazard stalls.

Parameters:
DEPTH, 2, entries per source FIFO (power of 2, >=2)
AW, 5, register address width
DW, 32, data width

Ports:
CLK  in  1  clock, rising edge
RSTa  in  1  asynchronous active-low reset
a_valid  in  1  ALU write request valid
a_reg  in  AW  ALU destination register
a_data  in  DW  ALU result
a_ready  out  1  ALU FIFO can accept
m_valid  in  1  load write request valid
m_reg  in  AW  load destination register
m_data  in  DW  load data
m_ready  out  1  load FIFO can accept
RegWrite  out  1  write enable to register file
writeReg  out  AW  write address to register file
writeData  out  DW  write data to register file
query_reg1  in  AW  decode source register 1
query_reg2  in  AW  decode source register 2
pending1  out  1  query_reg1 has a queued or in-flight write
pending2  out  1  query_reg2 has a queued or in-flight write
idle  out  1  both FIFOs empty and RegWrite low

Behaviour:
- Reset (RSTa low, async): FIFOs empty; pointers and counts 0; RegWrite=0, writeReg=0, writeData=0; a_ready=m_ready=1; pending1=pending2=0; idle=1; last-grant flag = A.
- Handshake: transfer occurs when x_valid && x_ready on a rising edge. x_ready = (count_x != DEPTH), so a full FIFO is never written in the same cycle it is popped. Producers hold valid/reg/data until accepted.
- x0 filter: an accepted request with reg==0 completes the handshake but is not enqueued. It never produces a write.
- Arbitration, each cycle:
  - grant = M if only M is non-empty; A if only A is non-empty.
  - If both are non-empty: policy per Optional Feature.
  - If both are empty: no grant.
  - The granted head is popped on that edge.
- Output register: on the edge that pops source S, RegWrite<=1, writeReg<=head_S.reg, writeData<=head_S.data. With no grant, RegWrite<=0 and writeReg/writeData hold their values.
- Latency: empty FIFO, request accepted at edge N, RegWrite high during cycle after edge N+1. The register file commits at edge N+2.
- Throughput: one write per cycle sustained. Simultaneous push and pop on the same FIFO are allowed; the count is unchanged.
- Pointers wrap modulo DEPTH. The count is AW-independent, clog2(DEPTH)+1 bits.
- Pending (combinational):
  - pendingK = 1 if query_regK != 0 and it matches any valid entry in either FIFO, or matches writeReg while RegWrite=1.
  - Pending never asserts for x0.
- Ordering: within a source, writes retire in FIFO order. Across sources, order is not guaranteed. Producers must not issue a write to a register whose pending bit is set by the other source; the decode stall enforces this.
- idle = (count_a==0) && (count_m==0) && !RegWrite.
- Reset mid-operation discards all queued writes. RegWrite drops immediately (async).

Optional Feature:
WB_RR_EN
- Defined: round-robin when both FIFOs are non-empty. Grant the source opposite to last-grant, then update last-grant on every grant.
- Undefined: fixed priority, M always wins over A. A may be delayed while M stays non-empty. The last-grant flag is unused.

Test Plan:
- Single write: reset, then a_valid with a_reg=5, a_data=0xDEADBEEF for one cycle.
  - RegWrite=1, writeReg=5, writeData=0xDEADBEEF exactly 2 edges after acceptance.
  - pending1 (query_reg1=5) high from acceptance until after the RegWrite cycle; idle returns 1.
- x0 drop: m_valid with m_reg=0, m_data=0x1234 -> m_ready=1 and handshake completes, RegWrite never asserts, pending for query 0 stays 0.
- Backpressure: hold a_valid for DEPTH+1 distinct writes (regs 1,2,3) while M floods so A cannot drain (fixed priority).
  - a_ready=0 after 2 accepts; the third is accepted only after an A pop.
  - Writes to regs 1 and 2 retire in order.
- Arbitration: both FIFOs hold 2 entries (A: r1,r2; M: r3,r4).
  - Without WB_RR_EN: write order r3,r4,r1,r2.
  - With WB_RR_EN: order r3,r1,r4,r2 (last-grant initialised to A).
- Full plus simultaneous pop: A FIFO full, pop and new push in the same cycle -> a_ready stays 0 that cycle, no overflow, count correct, no entry lost.
- Async reset mid-flight: assert RSTa low between edges with 3 entries queued and RegWrite=1.
  - RegWrite=0, pending=0, idle=1 immediately.
  - After release, no stale writes appear.
